offload_stream_sink: RTL and testbench
======================================

Name: offload_stream_sink

Overview:
- Synthesizable downstream consumer for Top's io_out stream (ready/valid/32-bit bits).
- Buffers accepted words in a small FIFO and drains them under a programmable stall pattern, to exercise Top's backpressure path.
- Checks every drained word against an expected value, then counts words and errors.
- Raises done once a programmed number of words has drained; this lets throughput-offload experiments run self-checking in hardware instead of in the bench.

Parameters:
- WIDTH, 32, data width of io_in_bits and of the expected/captured data.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the count, index and error counters.

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- io_in_ready  output  1  sink can accept a word this cycle.
- io_in_valid  input  1  upstream (Top io_out_valid) offers a word.
- io_in_bits  input  WIDTH  offered word.
- cfg_start  input  1  single-cycle pulse that starts a run; latches cfg_count, cfg_expect and cfg_stall_mask.
- cfg_count  input  CNT_W  number of words to accept and drain in the run.
- cfg_expect  input  WIDTH  value every drained word must equal.
- cfg_stall_mask  input  8  drain pattern; bit p=1 blocks draining in the cycle when the rotating pointer equals p.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- sink_count  output  CNT_W  words drained in the current run.
- err_count  output  CNT_W  mismatching drained words; saturates at all-ones.
- first_err_idx  output  CNT_W  sink_count value at the first mismatch.
- first_err_data  output  WIDTH  data of the first mismatching word.
- err_valid  output  1  at least one mismatch seen in the run.

Behaviour:
- Reset (synchronous; at any time, including mid-run):
  - state goes to IDLE and the FIFO empties.
  - All outputs are 0 in the cycle after reset: io_in_ready, busy, done, counters, first_err_*, err_valid.
  - Latched config is cleared and the stall pointer goes to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on cfg_start. This latches the config and clears the counters, error capture, accepted counter (acc_cnt) and stall pointer.
  - RUN -> DONE in the cycle after sink_count reaches the latched count.
  - If the latched count is 0, RUN -> DONE the cycle after entry, with nothing accepted.
  - DONE holds done=1 and all results stable until cfg_start, which behaves exactly as in IDLE: the run restarts with counters cleared.
  - cfg_start is ignored in RUN.
- Accept side:
  - io_in_ready = RUN and FIFO not full and acc_cnt < latched count. It depends only on registered state, never combinationally on io_in_valid.
  - A word is accepted when io_in_valid and io_in_ready are both high; acc_cnt then increments.
  - Words offered beyond count stay unaccepted: ready=0 and the word is neither dropped nor counted.
- Full is registered occupancy. If the FIFO is full, enqueue is blocked even when a dequeue happens in the same cycle; no bypass.
- Drain side:
  - stall pointer p increments modulo 8 every RUN cycle.
  - Drain occurs when the FIFO is not empty and cfg_stall_mask[p]=0.
  - Minimum latency is 1: a word accepted in cycle t drains no earlier than t+1. If the FIFO was empty, there is no same-cycle pass-through.
  - Simultaneous enqueue and dequeue when the FIFO is neither full nor empty leaves occupancy unchanged.
- Checking on each drain:
  - sink_count increments.
  - If the word differs from the latched expect, err_count increments (saturating).
  - On the first mismatch only: err_valid is set, first_err_idx takes the pre-increment sink_count, and first_err_data takes the word.
- Pointer wrap: the FIFO read/write pointers wrap modulo DEPTH, and occupancy is tracked by an explicit counter from 0 to DEPTH.
- A mask of all ones in RUN stalls draining forever. This is legal: busy stays 1 and there is no timeout.

Test Plan:
- Reset, then cfg_start with count=51, expect=2, mask=0x00; Top-like source sends 51 words of 2 with valid held high. Required: done=1, sink_count=51, err_count=0, err_valid=0; io_in_ready drops to 0 after the 51st accept.
- Same run with word index 7 = 0xDEADBEEF and index 20 = 5. Required: err_count=2, first_err_idx=7, first_err_data=0xDEADBEEF.
- mask=0xFF for 20 cycles, then 0x00 via restart with DEPTH=4. Required: exactly 4 words accepted, ready=0 while full, no word lost.
- mask=0xAA with continuous source, count=16. Required: drains occur only on even pointer values; done asserts and sink_count=16.
- count=0 start. Required: done=1 two cycles after cfg_start, io_in_ready never high, all counters 0.
- reset asserted mid-run after 10 accepts. Required: next cycle is IDLE with all outputs 0; a following run with count=3 completes with sink_count=3.

Source files
------------

// File: rtl/offload_stream_sink.sv
`default_nettype none
// =============================================================================
// offload_stream_sink : FIFO-buffered stream consumer, stall-pattern drain, data check
// Revision: 1.0
// =============================================================================
module offload_stream_sink #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             io_in_ready,
  input  logic             io_in_valid,
  input  logic [WIDTH-1:0] io_in_bits,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [WIDTH-1:0] cfg_expect,
  input  logic [7:0]       cfg_stall_mask,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sink_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_data,
  output logic             err_valid
);

  localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_OCC_W  = $clog2(DEPTH + 1);
  localparam logic [c_OCC_W-1:0] c_FULL = c_OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic [7:0]           mask_q, mask_d;
  logic [CNT_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     sink_q, sink_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [CNT_W-1:0]     eidx_q, eidx_d;
  logic [WIDTH-1:0]     edata_q, edata_d;
  logic                 ev_q, ev_d;
  logic [2:0]           ptr_q, ptr_d;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [c_ADDR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [c_OCC_W-1:0]   occ_q;

  logic                 w_full, w_push, w_pop;
  logic [WIDTH-1:0]     w_rd_data;

  // Full comes from registered occupancy only, so a same-cycle pop never frees a slot for a push.
  assign w_full      = (occ_q == c_FULL);
  assign io_in_ready = (state_q == S_RUN) && !w_full && (acc_q < cnt_q);
  assign w_push      = io_in_valid && io_in_ready;
  assign w_pop       = (state_q == S_RUN) && (occ_q != '0) && !mask_q[ptr_q];
  assign w_rd_data   = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    sink_d  = sink_q;
    err_d   = err_q;
    eidx_d  = eidx_q;
    edata_d = edata_q;
    ev_d    = ev_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_start) begin
          state_d = S_RUN;
          cnt_d   = cfg_count;
          exp_d   = cfg_expect;
          mask_d  = cfg_stall_mask;
          acc_d   = '0;
          sink_d  = '0;
          err_d   = '0;
          eidx_d  = '0;
          edata_d = '0;
          ev_d    = 1'b0;
          ptr_d   = '0;
        end
      end
      S_RUN: begin
        ptr_d = ptr_q + 3'd1;
        if (w_push) acc_d = acc_q + CNT_W'(1);
        if (w_pop) begin
          sink_d = sink_q + CNT_W'(1);
          if (w_rd_data != exp_q) begin
            if (err_q != '1) err_d = err_q + CNT_W'(1);
            if (!ev_q) begin
              ev_d    = 1'b1;
              eidx_d  = sink_q;
              edata_d = w_rd_data;
            end
          end
        end
        if (sink_q == cnt_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
      sink_q  <= '0;
      err_q   <= '0;
      eidx_q  <= '0;
      edata_q <= '0;
      ev_q    <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      sink_q  <= sink_d;
      err_q   <= err_d;
      eidx_q  <= eidx_d;
      edata_q <= edata_d;
      ev_q    <= ev_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_ADDR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_ADDR_W'(1);
      if (w_push && !w_pop)      occ_q <= occ_q + c_OCC_W'(1);
      else if (w_pop && !w_push) occ_q <= occ_q - c_OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= io_in_bits;
  end

  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign sink_count     = sink_q;
  assign err_count      = err_q;
  assign first_err_idx  = eidx_q;
  assign first_err_data = edata_q;
  assign err_valid      = ev_q;

endmodule
`default_nettype wire

// File: tb/tb_offload_stream_sink.sv
`default_nettype none
// =============================================================================
// tb_offload_stream_sink : randomized scoreboard bench for offload_stream_sink
// Revision: 1.0
// =============================================================================
module tb_offload_stream_sink;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             io_in_ready;
  logic             io_in_valid;
  logic [WIDTH-1:0] io_in_bits;
  logic             cfg_start;
  logic [CNT_W-1:0] cfg_count;
  logic [WIDTH-1:0] cfg_expect;
  logic [7:0]       cfg_stall_mask;
  logic             busy, done, err_valid;
  logic [CNT_W-1:0] sink_count, err_count, first_err_idx;
  logic [WIDTH-1:0] first_err_data;

  offload_stream_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .io_in_ready(io_in_ready), .io_in_valid(io_in_valid), .io_in_bits(io_in_bits),
    .cfg_start(cfg_start), .cfg_count(cfg_count), .cfg_expect(cfg_expect),
    .cfg_stall_mask(cfg_stall_mask),
    .busy(busy), .done(done), .sink_count(sink_count), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_data(first_err_data), .err_valid(err_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] src_q[$];
  logic [WIDTH-1:0] sb_q[$];
  bit               gap_en = 1'b0;
  bit               mon_on = 1'b0;
  int               acc_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source: presents the head of src_q; on a handshake the word moves to the scoreboard.
  initial begin : driver
    io_in_valid = 1'b0;
    io_in_bits  = '0;
    forever begin
      @(posedge clk);
      #1;
      io_in_valid = (src_q.size() > 0) && (!gap_en || ($urandom_range(0, 3) != 0));
      io_in_bits  = (src_q.size() > 0) ? src_q[0] : '0;
      @(negedge clk);
      if (io_in_valid && io_in_ready && !reset) begin
        sb_q.push_back(src_q.pop_front());
        acc_total++;
      end
    end
  end

  // Reference model: counts of accepted and drained words, run-relative cycle number for the mask.
  bit               m_run, m_done, m_ev;
  logic [CNT_W-1:0] m_cnt, m_acc, m_sink, m_err, m_eidx;
  logic [WIDTH-1:0] m_exp, m_edata;
  logic [7:0]       m_mask;
  int               m_k;

  initial begin : monitor
    bit               exp_ready, acc, drn, fin;
    logic [WIDTH-1:0] w;
    forever begin
      @(negedge clk);
      #2;
      if (mon_on) begin
        exp_ready = m_run && (int'(m_acc) - int'(m_sink) < DEPTH) && (m_acc < m_cnt);
        if (!reset) begin
          chk("io_in_ready", io_in_ready, exp_ready);
          chk("busy", busy, m_run);
          chk("done", done, m_done);
          chk("sink_count", sink_count, m_sink);
          chk("err_count", err_count, m_err);
          chk("err_valid", err_valid, m_ev);
          chk("first_err_idx", first_err_idx, m_eidx);
          chk("first_err_data", first_err_data, m_edata);
        end
        if (reset) begin
          m_run = 0; m_done = 0; m_ev = 0; m_cnt = '0; m_acc = '0; m_sink = '0;
          m_err = '0; m_eidx = '0; m_exp = '0; m_edata = '0; m_mask = '0; m_k = 0;
          sb_q.delete();
        end else if (cfg_start && !m_run) begin
          m_run = 1; m_done = 0; m_ev = 0; m_cnt = cfg_count; m_exp = cfg_expect;
          m_mask = cfg_stall_mask; m_acc = '0; m_sink = '0; m_err = '0;
          m_eidx = '0; m_edata = '0; m_k = 0;
        end else if (m_run) begin
          acc = io_in_valid && exp_ready;
          drn = (m_acc > m_sink) && !m_mask[m_k % 8];
          fin = (m_sink == m_cnt);
          if (drn) begin
            if (sb_q.size() == 0) begin
              chk("sb_underflow", 0, 1);
            end else begin
              w = sb_q.pop_front();
              if (w != m_exp) begin
                if (!m_ev) begin m_ev = 1; m_eidx = m_sink; m_edata = w; end
                if (m_err != '1) m_err = m_err + 1'b1;
              end
            end
            m_sink = m_sink + 1'b1;
          end
          if (acc) m_acc = m_acc + 1'b1;
          m_k++;
          if (fin) begin m_run = 0; m_done = 1; end
        end
      end
    end
  end

  task automatic start(input int cnt, input logic [WIDTH-1:0] ex, input logic [7:0] mask);
    @(posedge clk);
    #1;
    cfg_start = 1'b1; cfg_count = CNT_W'(cnt); cfg_expect = ex; cfg_stall_mask = mask;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_within_bound", done, 1'b1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin : main
    int base, cnt;
    logic [WIDTH-1:0] ex;
    logic [7:0] mask;
    reset = 1'b1; cfg_start = 1'b0; cfg_count = '0; cfg_expect = '0; cfg_stall_mask = '0;
    repeat (2) @(posedge clk);
    #1 mon_on = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_ready", io_in_ready, 0);

    // Clean 51-word run, valid held high
    for (int i = 0; i < 51; i++) src_q.push_back(32'd2);
    start(51, 32'd2, 8'h00);
    wait_done(400);
    chk("t1_sink", sink_count, 51);
    chk("t1_err", err_count, 0);
    chk("t1_ev", err_valid, 0);

    // Same run with two corrupted words, restarted from DONE
    for (int i = 0; i < 51; i++)
      src_q.push_back(i == 7 ? 32'hDEADBEEF : (i == 20 ? 32'd5 : 32'd2));
    start(51, 32'd2, 8'h00);
    wait_done(400);
    chk("t2_err", err_count, 2);
    chk("t2_eidx", first_err_idx, 7);
    chk("t2_edata", first_err_data, 32'hDEADBEEF);

    // Full stall: only DEPTH words accepted, then reset and deliver the held words
    for (int i = 0; i < 8; i++) src_q.push_back(32'd3);
    base = acc_total;
    start(8, 32'd3, 8'hFF);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_accepted", acc_total - base, DEPTH);
    chk("t3_ready_full", io_in_ready, 0);
    chk("t3_sink", sink_count, 0);
    chk("t3_busy", busy, 1);
    pulse_reset();
    chk("t3_rst_busy", busy, 0);
    start(4, 32'd3, 8'h00);
    wait_done(100);
    chk("t3_sink2", sink_count, 4);
    chk("t3_src_left", src_q.size(), 0);

    // Alternating stall mask
    for (int i = 0; i < 16; i++) src_q.push_back(32'h55);
    start(16, 32'h55, 8'hAA);
    wait_done(200);
    chk("t4_sink", sink_count, 16);

    // Zero-count run: done two cycles after cfg_start, nothing accepted
    src_q.push_back(32'h1);
    start(0, 32'h1, 8'h00);
    chk("t5_done_early", done, 0);
    @(posedge clk);
    #1;
    chk("t5_done", done, 1);
    chk("t5_sink", sink_count, 0);
    chk("t5_src_left", src_q.size(), 1);
    src_q.delete();

    // Mid-run reset after ten accepts, then a short run
    for (int i = 0; i < 30; i++) src_q.push_back(32'h9);
    base = acc_total;
    start(30, 32'h9, 8'h00);
    for (int i = 0; i < 200 && (acc_total - base) < 10; i++) @(posedge clk);
    chk("t6_reached_10", (acc_total - base) >= 10, 1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    src_q.delete();
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_sink", sink_count, 0);
    chk("t6_ready", io_in_ready, 0);
    for (int i = 0; i < 3; i++) src_q.push_back(32'h9);
    start(3, 32'h9, 8'h00);
    wait_done(50);
    chk("t6_sink2", sink_count, 3);

    // Randomized runs with valid gaps, mixed data and random stall masks
    gap_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      cnt  = $urandom_range(5, 40);
      ex   = $urandom;
      mask = 8'($urandom_range(0, 254));
      for (int i = 0; i < cnt; i++) src_q.push_back(($urandom_range(0, 4) == 0) ? $urandom : ex);
      start(cnt, ex, mask);
      wait_done(cnt * 40 + 100);
      chk("rnd_sink", sink_count, cnt);
    end
    gap_en = 1'b0;

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
